fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Master sequencer for the 256-point radix-2 in-place FFT.
- Walks the 8 stages and issues 128 butterflies per stage to the butterfly datapath over a valid/ready handshake, producing top and bottom sample addresses.
- Drives the twiddle index generator through stage_count_out, k_enable and k_clear, so the generator's k stays in lockstep with the butterfly currently being offered.
- Sits between the top-level FFT control (start/done) and the butterfly datapath, sample RAM and twiddle path.

Parameters:
- LOG2N, default 8: log2 of FFT length; number of stages.
- N, default 256: FFT length, equal to 2**LOG2N.
- NBF, default 128: butterflies per stage, equal to N/2.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- start  input  1  begin a transform; sampled only in IDLE.
- bf_ready  input  1  datapath accepts the offered butterfly.
- pipe_idle  input  1  datapath pipeline empty; all write-backs done.
- bf_valid  output  1  butterfly offered on addr_top, addr_bot.
- addr_top  output  8  top operand address.
- addr_bot  output  8  bottom operand address.
- stage_count_out  output  4  current stage, 0..7.
- k_enable  output  1  advance the twiddle k counter.
- k_clear  output  1  zero the twiddle k counter.
- busy  output  1  transform in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (nrst=0, async) forces state IDLE, stage=0 and j=0.
- Reset values: all outputs 0, including addr_top, addr_bot and stage_count_out.
- State IDLE: busy=0. start=1 moves to CLEAR with stage=0.
- State CLEAR (1 cycle): k_clear=1, bf_valid=0, j=0. Then move to ISSUE.
- State ISSUE:
  - bf_valid=1, busy=1.
  - Addresses for butterfly j in stage s: k = j mod 2**s; g = j >> s; addr_top = g*2**(s+1) + k; addr_bot = addr_top + 2**s.
  - Handshake: transfer occurs when bf_valid & bf_ready. k_enable = bf_valid & bf_ready, combinational, in the same cycle.
  - On transfer, j increments.
  - Transfer with j=127 moves to DRAIN.
  - bf_ready=0 holds the addresses, j and k stable; k_enable=0.
- State DRAIN: bf_valid=0. Wait for pipe_idle=1, minimum 1 cycle.
  - If stage==7, move to DONE.
  - Otherwise stage increments and the state moves to CLEAR.
- State DONE (1 cycle): done=1, busy=0. Then move to IDLE.
- busy=1 in CLEAR, ISSUE and DRAIN.
- stage_count_out changes only on entry to CLEAR. It is stable for the whole stage.
- Lockstep rule: the twiddle generator wraps k at 2**s. The internal k must equal the generator's registered index in every ISSUE cycle.
- Stage 0: k is always 0; every k_enable wraps the generator back to 0.
- Stage 7: k = j, 0..127.
- Boundary conditions:
  - start outside IDLE is ignored.
  - start held high through DONE starts a new run from IDLE.
  - Async reset mid-run aborts immediately to IDLE; no done pulse is generated.
  - pipe_idle is ignored outside DRAIN.
- Address arithmetic is 8-bit unsigned; no overflow is possible given the constraints above.
- Nominal length with bf_ready=1 and pipe_idle=1: 1 + 8*(1+128+1) = 1041 cycles from start accept to the done pulse.

Decomposition:
- Package fft_pkg holds: LOG2N, N, NBF, STAGE_W=4, ADDR_W=8, and typedef enum seq_state_t {IDLE, CLEAR, ISSUE, DRAIN, DONE}.
- One combinational sub-module, fft_bf_addr_gen: inputs stage and j; outputs addr_top, addr_bot and k. It is reused by the bench scoreboard.
- The FSM and the stage/j counters stay in fft_stage_sequencer.

Test Plan:
- Reset/idle: nrst pulsed low mid-cycle -> all outputs 0 asynchronously; no bf_valid without start.
- Stage 0 issue, bf_ready=1: start -> 1 cycle k_clear=1, then (0,1), (2,3), (4,6)... is wrong; required sequence is (0,1), (2,3), (4,5), with k_enable=1 every cycle and the generator index always 0.
- Stage 2, j=5: k=1, g=1 -> addr_top=9, addr_bot=13, generator index 1. Stage 7, j=127 -> (127,255).
- Backpressure: bf_ready=0 for 3 cycles at stage 3, j=10 -> addresses held at (18,26), k_enable=0, j unchanged; the transfer on release advances to j=11.
- Drain: pipe_idle=0 for 5 cycles after stage 4 -> no k_clear and no stage change until pipe_idle=1; then CLEAR with stage_count_out=5.
- Full run with a random bf_ready/pipe_idle pattern: exactly 1024 transfers, each matching the model; done is a single pulse; start during busy is ignored; reset at stage 6 returns to IDLE with no done.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the 256-point radix-2 in-place FFT control
// path. Imported by the stage sequencer and its butterfly address generator.
//   LOG2N   : number of stages (log2 of the transform length)
//   N       : transform length
//   NBF     : butterflies issued per stage
//   STAGE_W : width of the stage counter / stage_count_out
//   ADDR_W  : width of a sample RAM address
//   J_W     : width of the in-stage butterfly index j
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int LOG2N   = 8;
  localparam int N       = 2 ** LOG2N;
  localparam int NBF     = N / 2;
  localparam int STAGE_W = 4;
  localparam int ADDR_W  = LOG2N;
  localparam int J_W     = LOG2N - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fft_stage_sequencer_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_bf_addr_gen
// Purely combinational butterfly address generator for an in-place radix-2
// FFT. For butterfly j of stage s:
//   k        = j mod 2**s          (twiddle index)
//   g        = j >> s              (butterfly group)
//   addr_top = g * 2**(s+1) + k
//   addr_bot = addr_top + 2**s
// Ports:
//   stage_i    : current stage, 0..LOG2N-1
//   j_i        : butterfly index within the stage, 0..NBF-1
//   addr_top_o : top operand address
//   addr_bot_o : bottom operand address
//   k_o        : twiddle index for this butterfly
// -----------------------------------------------------------------------------
module fft_bf_addr_gen
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0] stage_i,
  input  logic [J_W-1:0]     j_i,
  output logic [ADDR_W-1:0]  addr_top_o,
  output logic [ADDR_W-1:0]  addr_bot_o,
  output logic [J_W-1:0]     k_o
);

  logic [ADDR_W-1:0] span_s;
  logic [ADDR_W-1:0] mask_s;
  logic [ADDR_W-1:0] j_ext_s;
  logic [ADDR_W-1:0] k_ext_s;
  logic [ADDR_W-1:0] group_s;

  // Split j into group and in-group offset, then place the pair in memory.
  always_comb begin
    span_s     = ADDR_W'(1) << stage_i;
    mask_s     = span_s - ADDR_W'(1);
    j_ext_s    = {1'b0, j_i};
    k_ext_s    = j_ext_s & mask_s;
    group_s    = j_ext_s >> stage_i;
    // g * 2**(s+1) never exceeds 255 because g < 2**(7-s).
    addr_top_o = (group_s << (stage_i + STAGE_W'(1))) + k_ext_s;
    addr_bot_o = addr_top_o + span_s;
    k_o        = j_i & mask_s[J_W-1:0];
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
// Master sequencer for the 256-point radix-2 in-place FFT. Walks the 8 stages,
// offers 128 butterflies per stage over a valid/ready handshake and keeps the
// external twiddle index generator in lockstep via k_clear / k_enable.
// Ports:
//   clk             : clock, rising edge
//   nrst            : asynchronous active-low reset
//   start           : begin a transform (only looked at in IDLE)
//   bf_ready        : datapath accepts the offered butterfly
//   pipe_idle       : datapath pipeline empty (only looked at in DRAIN)
//   bf_valid        : butterfly offered on addr_top / addr_bot
//   addr_top        : top operand address
//   addr_bot        : bottom operand address
//   stage_count_out : current stage 0..7, changes only on entry to CLEAR
//   k_enable        : advance twiddle k (combinational: bf_valid & bf_ready)
//   k_clear         : zero twiddle k (asserted for the CLEAR cycle)
//   busy            : transform in progress (CLEAR, ISSUE, DRAIN)
//   done            : one-cycle completion pulse
// -----------------------------------------------------------------------------
module fft_stage_sequencer
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               bf_ready,
  input  logic               pipe_idle,
  output logic               bf_valid,
  output logic [ADDR_W-1:0]  addr_top,
  output logic [ADDR_W-1:0]  addr_bot,
  output logic [STAGE_W-1:0] stage_count_out,
  output logic               k_enable,
  output logic               k_clear,
  output logic               busy,
  output logic               done
);

  localparam logic [J_W-1:0]     J_LAST     = J_W'(NBF - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);

  seq_state_t         state_q;
  logic [STAGE_W-1:0] stage_q;
  logic [J_W-1:0]     j_q;
  logic               bf_valid_q;
  logic [ADDR_W-1:0]  addr_top_q;
  logic [ADDR_W-1:0]  addr_bot_q;
  logic               k_clear_q;
  logic               busy_q;
  logic               done_q;

  logic [J_W-1:0]     gen_j_s;
  logic [ADDR_W-1:0]  gen_top_s;
  logic [ADDR_W-1:0]  gen_bot_s;
  logic [J_W-1:0]     unused_k_s;

  // The generator looks one butterfly ahead so the address registers can be
  // loaded on the same edge that advances j (j=0 when leaving CLEAR).
  assign gen_j_s = (state_q == ISSUE) ? (j_q + J_W'(1)) : {J_W{1'b0}};

  fft_bf_addr_gen u_addr_gen (
    .stage_i    (stage_q),
    .j_i        (gen_j_s),
    .addr_top_o (gen_top_s),
    .addr_bot_o (gen_bot_s),
    .k_o        (unused_k_s)
  );

  // Sequencer FSM, stage/j counters and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      stage_q    <= {STAGE_W{1'b0}};
      j_q        <= {J_W{1'b0}};
      bf_valid_q <= 1'b0;
      addr_top_q <= {ADDR_W{1'b0}};
      addr_bot_q <= {ADDR_W{1'b0}};
      k_clear_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      k_clear_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= CLEAR;
            stage_q   <= {STAGE_W{1'b0}};
            j_q       <= {J_W{1'b0}};
            k_clear_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          state_q    <= ISSUE;
          j_q        <= {J_W{1'b0}};
          bf_valid_q <= 1'b1;
          addr_top_q <= gen_top_s;
          addr_bot_q <= gen_bot_s;
        end
        ISSUE: begin
          // Without ready everything holds, so the twiddle k holds too.
          if (bf_ready) begin
            if (j_q == J_LAST) begin
              state_q    <= DRAIN;
              j_q        <= {J_W{1'b0}};
              bf_valid_q <= 1'b0;
              addr_top_q <= {ADDR_W{1'b0}};
              addr_bot_q <= {ADDR_W{1'b0}};
            end else begin
              j_q        <= j_q + J_W'(1);
              addr_top_q <= gen_top_s;
              addr_bot_q <= gen_bot_s;
            end
          end
        end
        DRAIN: begin
          // Next stage reads what this stage wrote, so wait for write-backs.
          if (pipe_idle) begin
            if (stage_q == STAGE_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= CLEAR;
              stage_q   <= stage_q + STAGE_W'(1);
              k_clear_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          bf_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bf_valid        = bf_valid_q;
  assign addr_top        = addr_top_q;
  assign addr_bot        = addr_bot_q;
  assign stage_count_out = stage_q;
  assign k_clear         = k_clear_q;
  assign busy            = busy_q;
  assign done            = done_q;
  // Same-cycle advance keeps the generator's k aligned with the offered j.
  assign k_enable        = bf_valid_q & bf_ready;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_sequencer
// Self-checking bench for fft_stage_sequencer. A negedge monitor holds a
// reference model: per stage, the list of butterfly pairs (a, a + 2**s) with
// bit s of a clear, in ascending order, plus a model twiddle generator that
// clears on k_clear and wraps at 2**stage on k_enable. Directed sequences
// cover reset, stage-0 start-up, backpressure, drain hold, nominal length,
// start held through DONE and a mid-run abort; a vector table checks
// recorded transfers at specific (stage, j) points.
// -----------------------------------------------------------------------------
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       bf_ready = 1'b0;
  logic       pipe_idle = 1'b0;
  logic       bf_valid;
  logic [7:0] addr_top;
  logic [7:0] addr_bot;
  logic [3:0] stage_count_out;
  logic       k_enable;
  logic       k_clear;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  fft_stage_sequencer dut (
    .clk             (clk),
    .nrst            (nrst),
    .start           (start),
    .bf_ready        (bf_ready),
    .pipe_idle       (pipe_idle),
    .bf_valid        (bf_valid),
    .addr_top        (addr_top),
    .addr_bot        (addr_bot),
    .stage_count_out (stage_count_out),
    .k_enable        (k_enable),
    .k_clear         (k_clear),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    int stage;
    int j;
    int top;
    int bot;
    int k;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   ref_top [8][128];
  int   ref_bot [8][128];
  int   obs_top [8][128];
  int   obs_bot [8][128];
  int   obs_k   [8][128];
  vec_t tbl [10];

  // monitor model state
  int   m_stage = -1;
  int   m_j = 0;
  int   m_gen_k = 0;
  int   m_xfers = 0;
  logic m_done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bf_valid"}, bf_valid, 0);
    chk({tag, "_addr_top"}, addr_top, 0);
    chk({tag, "_addr_bot"}, addr_bot, 0);
    chk({tag, "_stage"}, stage_count_out, 0);
    chk({tag, "_k_enable"}, k_enable, 0);
    chk({tag, "_k_clear"}, k_clear, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Reference monitor: compares every offered butterfly and the twiddle lockstep.
  always @(negedge clk) begin
    if (!nrst) begin
      m_stage = -1;
      m_j = 0;
      m_gen_k = 0;
      m_xfers = 0;
      m_done_prev = 1'b0;
    end else begin
      if (k_clear) begin
        chk("kclr_stage", stage_count_out, (m_stage < 0) ? 0 : m_stage + 1);
        chk("kclr_valid", bf_valid, 0);
        if (m_stage >= 0) chk("kclr_prev_complete", m_j, 128);
        if (m_stage < 0) begin
          m_xfers = 0;
          m_stage = 0;
        end else begin
          m_stage = m_stage + 1;
        end
        m_j = 0;
      end
      if (bf_valid) begin
        if (m_stage < 0 || m_stage > 7 || m_j >= 128) begin
          chk("unexpected_valid", bf_valid, 0);
        end else begin
          chk("addr_top", addr_top, ref_top[m_stage][m_j]);
          chk("addr_bot", addr_bot, ref_bot[m_stage][m_j]);
          chk("twiddle_lockstep", m_gen_k, ref_top[m_stage][m_j] % (1 << m_stage));
          chk("stage_stable", stage_count_out, m_stage);
          chk("k_enable", k_enable, bf_ready);
          if (bf_ready) begin
            obs_top[m_stage][m_j] = addr_top;
            obs_bot[m_stage][m_j] = addr_bot;
            obs_k[m_stage][m_j]   = m_gen_k;
            m_j++;
            m_xfers++;
          end
        end
      end else begin
        chk("k_enable_no_valid", k_enable, 0);
      end
      if (done) begin
        chk("done_xfers", m_xfers, 1024);
        chk("done_busy", busy, 0);
        chk("done_single_pulse", m_done_prev, 0);
        m_stage = -1;
      end
      m_done_prev = done;
      if (k_clear) m_gen_k = 0;
      else if (k_enable) m_gen_k = (m_gen_k + 1) % (1 << stage_count_out);
    end
  end

  initial begin
    bit seen_done;
    bit bp_done;
    bit dr_done;
    int n;

    // Reference pair lists: a with bit s clear, ascending; partner a + 2**s.
    for (int s = 0; s < 8; s++) begin
      int idx = 0;
      for (int a = 0; a < 256; a++) begin
        if (((a >> s) & 1) == 0) begin
          ref_top[s][idx] = a;
          ref_bot[s][idx] = a + (1 << s);
          idx++;
        end
      end
      for (int j = 0; j < 128; j++) begin
        obs_top[s][j] = -1;
        obs_bot[s][j] = -1;
        obs_k[s][j]   = -1;
      end
    end

    tbl[0] = '{0, 0, 0, 1, 0};
    tbl[1] = '{0, 1, 2, 3, 0};
    tbl[2] = '{0, 2, 4, 5, 0};
    tbl[3] = '{1, 3, 5, 7, 1};
    tbl[4] = '{2, 5, 9, 13, 1};
    tbl[5] = '{3, 10, 18, 26, 2};
    tbl[6] = '{4, 20, 36, 52, 4};
    tbl[7] = '{5, 33, 65, 97, 1};
    tbl[8] = '{6, 64, 128, 192, 0};
    tbl[9] = '{7, 127, 127, 255, 127};

    // Reset state and idle with no start.
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("idle_valid", bf_valid, 0);
      chk("idle_busy", busy, 0);
    end

    // Run 1: stage-0 start-up with ready held high.
    start = 1'b1;
    bf_ready = 1'b1;
    pipe_idle = 1'b1;
    cycle();
    start = 1'b0;
    chk("clear_k_clear", k_clear, 1);
    chk("clear_valid", bf_valid, 0);
    chk("clear_busy", busy, 1);
    chk("clear_stage", stage_count_out, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("s0_top", addr_top, 2 * i);
      chk("s0_bot", addr_bot, 2 * i + 1);
      chk("s0_k_enable", k_enable, 1);
    end

    // Rest of run 1: random ready/idle/start with two directed corners.
    seen_done = 1'b0;
    bp_done = 1'b0;
    dr_done = 1'b0;
    for (int c = 0; c < 20000 && !seen_done; c++) begin
      if (!bp_done && bf_valid && stage_count_out == 4'd3 && addr_top == 8'd18) begin
        bf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #1;
          chk("bp_k_enable", k_enable, 0);
          cycle();
          chk("bp_top", addr_top, 18);
          chk("bp_bot", addr_bot, 26);
          chk("bp_valid", bf_valid, 1);
        end
        bf_ready = 1'b1;
        #1;
        chk("bp_release_k_enable", k_enable, 1);
        cycle();
        chk("bp_next_top", addr_top, 19);
        chk("bp_next_bot", addr_bot, 27);
        bp_done = 1'b1;
      end else if (!dr_done && busy && !bf_valid && !k_clear && stage_count_out == 4'd4) begin
        pipe_idle = 1'b0;
        for (int i = 0; i < 5; i++) begin
          cycle();
          chk("drain_k_clear", k_clear, 0);
          chk("drain_stage", stage_count_out, 4);
          chk("drain_busy", busy, 1);
          chk("drain_valid", bf_valid, 0);
        end
        pipe_idle = 1'b1;
        cycle();
        chk("drain_exit_k_clear", k_clear, 1);
        chk("drain_exit_stage", stage_count_out, 5);
        dr_done = 1'b1;
      end else begin
        bf_ready  = ($urandom_range(0, 3) != 0);
        pipe_idle = ($urandom_range(0, 2) != 0);
        start     = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      cycle();
      if (done) seen_done = 1'b1;
    end
    start = 1'b0;
    chk("run1_done_seen", seen_done, 1);
    chk("run1_bp_reached", bp_done, 1);
    chk("run1_drain_reached", dr_done, 1);
    cycle();
    chk("after_done_busy", busy, 0);
    chk("after_done_done", done, 0);

    // Vector table against transfers recorded during run 1.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tbl%0d_top", i), obs_top[tbl[i].stage][tbl[i].j], tbl[i].top);
      chk($sformatf("tbl%0d_bot", i), obs_bot[tbl[i].stage][tbl[i].j], tbl[i].bot);
      chk($sformatf("tbl%0d_k", i), obs_k[tbl[i].stage][tbl[i].j], tbl[i].k);
    end

    // Run 2: nominal length with start held high through DONE.
    start = 1'b1;
    bf_ready = 1'b1;
    pipe_idle = 1'b1;
    n = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 2000 && !seen_done; c++) begin
      cycle();
      n++;
      if (done) seen_done = 1'b1;
    end
    chk("run2_done_seen", seen_done, 1);
    chk("nominal_length", n, 1041);
    cycle();
    chk("restart_idle_busy", busy, 0);
    chk("restart_idle_done", done, 0);
    cycle();
    start = 1'b0;
    chk("restart_k_clear", k_clear, 1);
    chk("restart_stage", stage_count_out, 0);

    // Run 3: abort with async reset in the middle of stage 6.
    n = 0;
    while (n < 2000 && !(bf_valid && stage_count_out == 4'd6)) begin
      cycle();
      n++;
    end
    chk("abort_stage6_reached", stage_count_out, 6);
    #2;
    nrst = 1'b0;
    #1;
    chk_all_zero("abort");
    cycle();
    nrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("post_abort_done", done, 0);
      chk("post_abort_valid", bf_valid, 0);
      chk("post_abort_busy", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
